// File: rtl/ret_addr_stack.sv
// Return-address stack: LIFO of CALL return addresses (pc_in + 1) with a
// registered pop output, fill level and sticky overflow/underflow flags.
module ret_addr_stack #(
  parameter int AW    = 8,
  parameter int DEPTH = 8,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          call,
  input  logic          ret,
  input  logic [AW-1:0] pc_in,
  input  logic          clr_err,
  output logic [AW-1:0] top,
  output logic [AW-1:0] ret_pc,
  output logic          ret_valid,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          ovf,
  output logic          unf
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0] mem [DEPTH];
  logic [IW-1:0] top_idx;
  logic [IW-1:0] wr_idx;
  logic [AW-1:0] push_val;
  logic [CW-1:0] count_nxt;
  logic          do_pop;
  logic          do_swap;
  logic          do_push;
  logic          wr_en;
  logic          ovf_set;
  logic          unf_set;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign top_idx  = IW'(count - CW'(1));
  assign top      = empty ? '0 : mem[top_idx];
  assign push_val = pc_in + AW'(1);

  // Simultaneous call/ret on a non-empty stack replaces the top in place.
  assign do_pop   = ret && !empty;
  assign do_swap  = call && do_pop;
  assign do_push  = call && !ret && !full || call && ret && empty;
  assign wr_en    = do_push || do_swap;
  assign wr_idx   = do_swap ? top_idx : IW'(count);
  assign ovf_set  = call && !ret && full;
  assign unf_set  = ret && empty;

  always_comb begin
    count_nxt = count;
    if (do_push)
      count_nxt = count + CW'(1);
    else if (do_pop && !do_swap)
      count_nxt = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      ret_pc    <= '0;
      ret_valid <= 1'b0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
    end else begin
      count     <= count_nxt;
      ret_valid <= do_pop;
      if (do_pop)
        ret_pc <= top;
      ovf <= (ovf && !clr_err) || ovf_set;
      unf <= (unf && !clr_err) || unf_set;
    end
  end

  // Entry storage is never cleared; only the write strobe is reset-gated.
  always_ff @(posedge clk) begin
    if (!rst && wr_en)
      mem[wr_idx] <= push_val;
  end

endmodule

// File: tb/tb_ret_addr_stack.sv
// Directed bench for ret_addr_stack: a queue model of the stack plus a
// scoreboard of expected popped addresses compared when ret_valid pulses.
module tb_ret_addr_stack;

  logic       clk = 1'b0;
  logic       rst, call, ret, clr_err;
  logic [7:0] pc_in;
  logic [7:0] top, ret_pc;
  logic       ret_valid, empty, full, ovf, unf;
  logic [3:0] count;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] mstk [$];
  logic [7:0] exp_q [$];
  logic       m_ovf, m_unf, m_vld;
  logic [7:0] m_retpc;

  ret_addr_stack #(.AW(8), .DEPTH(8), .CW(4)) dut (
    .clk(clk), .rst(rst), .call(call), .ret(ret), .pc_in(pc_in),
    .clr_err(clr_err), .top(top), .ret_pc(ret_pc), .ret_valid(ret_valid),
    .count(count), .empty(empty), .full(full), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic chk_all(input string tag);
    logic [7:0] etop;
    etop = (mstk.size() > 0) ? mstk[mstk.size()-1] : 8'h00;
    chk({tag, ".count"},     32'(count),     32'(mstk.size()));
    chk({tag, ".top"},       32'(top),       32'(etop));
    chk({tag, ".empty"},     32'(empty),     32'(mstk.size() == 0));
    chk({tag, ".full"},      32'(full),      32'(mstk.size() == 8));
    chk({tag, ".ovf"},       32'(ovf),       32'(m_ovf));
    chk({tag, ".unf"},       32'(unf),       32'(m_unf));
    chk({tag, ".ret_valid"}, 32'(ret_valid), 32'(m_vld));
    chk({tag, ".ret_pc"},    32'(ret_pc),    32'(m_retpc));
    if (ret_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk({tag, ".sb_empty"}, 32'(1), 32'(0));
      end else begin
        chk({tag, ".sb"}, 32'(ret_pc), 32'(exp_q.pop_front()));
      end
    end
  endtask

  // One clock of stimulus; the model advances from the pre-edge state.
  task automatic step(input string tag, input logic c, input logic r,
                      input logic [7:0] pc, input logic clr);
    logic [7:0] pv;
    pv = pc + 8'd1;
    m_vld = 1'b0;
    if (clr) begin m_ovf = 1'b0; m_unf = 1'b0; end
    if (c && r) begin
      if (mstk.size() > 0) begin
        m_retpc = mstk[mstk.size()-1];
        exp_q.push_back(m_retpc);
        m_vld = 1'b1;
        mstk[mstk.size()-1] = pv;
      end else begin
        m_unf = 1'b1;
        mstk.push_back(pv);
      end
    end else if (c) begin
      if (mstk.size() == 8) m_ovf = 1'b1;
      else mstk.push_back(pv);
    end else if (r) begin
      if (mstk.size() > 0) begin
        m_retpc = mstk.pop_back();
        exp_q.push_back(m_retpc);
        m_vld = 1'b1;
      end else begin
        m_unf = 1'b1;
      end
    end
    rst = 1'b0; call = c; ret = r; pc_in = pc; clr_err = clr;
    @(posedge clk);
    #1;
    call = 1'b0; ret = 1'b0; clr_err = 1'b0;
    chk_all(tag);
  endtask

  task automatic do_reset(input string tag, input logic c, input logic r);
    rst = 1'b1; call = c; ret = r; pc_in = 8'($urandom); clr_err = 1'b0;
    mstk.delete(); exp_q.delete();
    m_ovf = 1'b0; m_unf = 1'b0; m_vld = 1'b0; m_retpc = 8'h00;
    @(posedge clk);
    #1;
    rst = 1'b0; call = 1'b0; ret = 1'b0;
    chk_all(tag);
  endtask

  initial begin
    rst = 1'b1; call = 1'b0; ret = 1'b0; clr_err = 1'b0; pc_in = 8'h00;

    // Reset with random strobes
    do_reset("rst0", 1'($urandom), 1'($urandom));
    do_reset("rst1", 1'b1, 1'b1);
    chk("rst.top_const", 32'(top), 32'h00);

    // Single call / return
    step("call10", 1'b1, 1'b0, 8'h10, 1'b0);
    chk("call10.top_const", 32'(top), 32'h11);
    step("ret11", 1'b0, 1'b1, 8'h00, 1'b0);
    chk("ret11.ret_pc_const", 32'(ret_pc), 32'h11);
    step("idle", 1'b0, 1'b0, 8'h00, 1'b0);

    // Fill and overflow
    for (int i = 0; i < 8; i++) step("fill", 1'b1, 1'b0, 8'(i), 1'b0);
    chk("fill.count_const", 32'(count), 32'd8);
    chk("fill.top_const", 32'(top), 32'h08);
    step("ovf", 1'b1, 1'b0, 8'h40, 1'b0);
    chk("ovf.flag_const", 32'(ovf), 32'd1);
    chk("ovf.top_const", 32'(top), 32'h08);
    for (int i = 0; i < 8; i++) begin
      step("drain", 1'b0, 1'b1, 8'h00, 1'b0);
      chk("drain.ret_pc_const", 32'(ret_pc), 32'(8 - i));
    end

    // Wrap and underflow
    step("wrap", 1'b1, 1'b0, 8'hFF, 1'b0);
    chk("wrap.top_const", 32'(top), 32'h00);
    step("wrap_ret", 1'b0, 1'b1, 8'h00, 1'b0);
    step("unf", 1'b0, 1'b1, 8'h00, 1'b0);
    chk("unf.flag_const", 32'(unf), 32'd1);
    step("clr_set", 1'b0, 1'b1, 8'h00, 1'b1);
    chk("clr_set.unf_const", 32'(unf), 32'd1);
    step("clr", 1'b0, 1'b0, 8'h00, 1'b1);
    chk("clr.unf_const", 32'(unf), 32'd0);

    // Simultaneous call/ret
    step("b1", 1'b1, 1'b0, 8'h01, 1'b0);
    step("b2", 1'b1, 1'b0, 8'h02, 1'b0);
    step("b3", 1'b1, 1'b0, 8'h20, 1'b0);
    step("swap3", 1'b1, 1'b1, 8'h50, 1'b0);
    chk("swap3.ret_pc_const", 32'(ret_pc), 32'h21);
    chk("swap3.top_const", 32'(top), 32'h51);
    for (int i = 0; i < 5; i++) step("b_fill", 1'b1, 1'b0, 8'h60 + 8'(i), 1'b0);
    step("swap8", 1'b1, 1'b1, 8'h70, 1'b0);
    chk("swap8.count_const", 32'(count), 32'd8);
    chk("swap8.ovf_const", 32'(ovf), 32'd0);
    step("swap_empty_pre", 1'b0, 1'b0, 8'h00, 1'b0);

    // Reset mid-stream
    for (int i = 0; i < 3; i++) step("to5", 1'b0, 1'b1, 8'h00, 1'b0);
    chk("to5.count_const", 32'(count), 32'd5);
    do_reset("rst_mid", 1'b1, 1'b0);
    step("call30", 1'b1, 1'b0, 8'h30, 1'b0);
    chk("call30.top_const", 32'(top), 32'h31);

    // Call and ret together on an empty stack
    step("ce_ret", 1'b0, 1'b1, 8'h00, 1'b0);
    step("ce_both", 1'b1, 1'b1, 8'h80, 1'b0);
    chk("ce_both.top_const", 32'(top), 32'h81);

    chk("sb.drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ret_addr_stack.md
# ret_addr_stack

Hardware return-address stack for the single-cycle CPU. It extends the single-entry link register into a LIFO of return addresses. On CALL it pushes the return address (current PC + 1); on RET it pops the most recent one back to the PC-select logic. It sits beside the PC/branch unit, is driven by decoded `call`/`ret` strobes, and reports fill level plus sticky overflow/underflow flags for debug.

## Interface
- `AW`, 8, address width of PC and stored entries
- `DEPTH`, 8, number of stack entries (power of two, ≥2)
- `CW`, 4, width of `count`, equal to clog2(DEPTH+1)

- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset; synchronous, active-high
- `call`  in  1  push request, one strobe per CALL instruction
- `ret`  in  1  pop request, one strobe per RET instruction
- `pc_in`  in  AW  address of the CALL instruction
- `clr_err`  in  1  clears `ovf` and `unf`
- `top`  out  AW  current top-of-stack entry; 0 when empty
- `ret_pc`  out  AW  registered popped address
- `ret_valid`  out  1  one-cycle pulse: `ret_pc` updated by a successful pop
- `count`  out  CW  number of valid entries, 0..DEPTH
- `empty`  out  1  `count == 0`
- `full`  out  1  `count == DEPTH`
- `ovf`  out  1  sticky: push attempted while full
- `unf`  out  1  sticky: pop attempted while empty

## Operation
- Storage: DEPTH×AW register array, stack pointer `sp` = `count`. Entries are written at index `sp` and the top is read at index `sp-1`.
- Pushed value is `pc_in + 1` truncated to AW bits (0xFF → 0x00 for AW=8).
- Push only (`call=1`, `ret=0`):
  - not full: write entry, `count+1`
  - full: no write, `count` unchanged, `ovf<=1`. There is no wrap and no overwrite of the oldest entry.
- Pop only (`ret=1`, `call=0`):
  - not empty: `ret_pc <=` top, `ret_valid<=1`, `count-1`
  - empty: `count` unchanged, `ret_pc` holds, `ret_valid<=0`, `unf<=1`
- Push and pop together:
  - not empty (including full): `ret_pc <=` old top, `ret_valid<=1`, top entry overwritten with `pc_in+1`, `count` unchanged, `ovf` not set
  - empty: `unf<=1`, `ret_valid<=0`, push performed, `count` becomes 1
- Neither: all state holds; `ret_valid<=0`.
- Sticky flags:
  - `clr_err` clears `ovf`/`unf`.
  - If an error condition occurs in the same cycle as `clr_err`, the new error sets its flag (set wins).
- `top`, `empty`, `full` are combinational from `count` and the array. `top` is forced to 0 when empty.
- Entries above `sp` are don't-care and are not reset.

## Timing
- All state updates on rising `clk`.
- Synchronous `rst` has priority over every input. After the reset edge: `count=0`, `empty=1`, `full=0`, `top=0`, `ret_pc=0`, `ret_valid=0`, `ovf=0`, `unf=0`.
- Reset mid-operation discards all entries. A `call`/`ret` in the reset cycle is ignored.
- Push latency:
  - `call` sampled at edge N, so `top`/`count` reflect the push after edge N.
  - A `ret` in cycle N+1 pops that value.
- Pop latency: `ret` sampled at edge N gives `ret_pc`/`ret_valid` valid after edge N, for exactly one cycle. `ret_pc` then holds its value, and `ret_valid` drops unless another pop occurs.
- `top` is valid combinationally within the same cycle for same-cycle PC selection. `ret_pc` is the registered copy.
- No handshake or backpressure: every strobe is consumed in one cycle. Back-to-back strobes on every cycle are legal.

## Test plan
- Reset: drive random `call`/`ret` with `rst=1` → after the edge, `count=0`, `empty=1`, `top=0x00`, `ret_valid=0`, `ovf=unf=0`.
- Single call/return: `call`, `pc_in=0x10` → `top=0x11`, `count=1`; then `ret` → `ret_pc=0x11`, `ret_valid=1` for one cycle, `empty=1`.
- Fill and overflow:
  - 8 calls with `pc_in=0x00..0x07` → `full=1`, `count=8`, `top=0x08`
  - 9th call with `pc_in=0x40` → `ovf=1`, `top=0x08`
  - 8 rets → `ret_pc` sequence 0x08,0x07,…,0x01
- Wrap and underflow:
  - call with `pc_in=0xFF` → `top=0x00`, `empty=0`
  - ret, then ret on empty → `unf=1`, `ret_valid=0`, `ret_pc` stays 0x00
  - `clr_err` together with another empty ret → `unf` stays 1
  - `clr_err` alone → `unf=0`
- Simultaneous call/ret:
  - at `count=3` with top 0x21, `pc_in=0x50` → `ret_pc=0x21`, `ret_valid=1`, `top=0x51`, `count=3`
  - repeat at `count=8` → `ovf=0`, `count=8`
- Reset mid-stream: at `count=5`, assert `rst` together with `call` → `count=0`, `empty=1`, `top=0x00`. The next call with `pc_in=0x30` → `top=0x31`, `count=1`.
